// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output stage.
//   CONV_WORD_SIZE : default pixel width in bits
//   KERNEL_DIM     : convolution kernel edge; output frame loses KERNEL_DIM-1 rows/cols
//   cfw_state_t    : frame writer FSM states
// The {addr, data} FIFO entry depends on module parameters, so each user declares its
// own wr_entry_t with the widths it was built with.
package conv_pkg;

    localparam int unsigned CONV_WORD_SIZE = 8;
    localparam int unsigned KERNEL_DIM     = 3;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        DONE
    } cfw_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read/write pointers and an occupancy count.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write din_i (taken when not full, or when full and popping this cycle)
//   pop_i     : drop the head entry (ignored when empty)
//   din_i     : write data
//   dout_o    : head entry, valid while empty_o is low
//   full_o    : Depth entries held
//   empty_o   : no entries held
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(Depth);
    localparam int unsigned CNT_W = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(Depth));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible while not empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/conv_frame_writer.sv
// Writes one convolution output frame into frame memory.
//   clk, rst    : clock, synchronous active-high reset
//   start       : arm capture of one frame (IDLE only)
//   pixel_in    : convolution output pixel
//   valid_in    : convolution valid, bit 0 used; leads pixel_in by VALID_DELAY cycles
//   mem_wr_en   : FIFO head valid (write request)
//   mem_wr_addr : linear address row*OUT_W+col of the head entry
//   mem_wr_data : pixel of the head entry
//   mem_ready   : memory takes the head this cycle
//   busy        : high in CAPTURE and DRAIN
//   frame_done  : one-cycle pulse after the frame has fully drained
//   overflow    : sticky, a pixel was dropped because the FIFO was full
module conv_frame_writer
    import conv_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = CONV_WORD_SIZE,
    parameter int unsigned ROW_SIZE    = 540,
    parameter int unsigned COL_SIZE    = 540,
    parameter int unsigned VALID_DELAY = 3,
    parameter int unsigned FIFO_DEPTH  = 8,
    localparam int unsigned OUT_W      = ROW_SIZE - (KERNEL_DIM - 1),
    localparam int unsigned OUT_H      = COL_SIZE - (KERNEL_DIM - 1),
    localparam int unsigned ADDR_W     = $clog2(OUT_W * OUT_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] pixel_in,
    input  logic [1:0]           valid_in,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic [WORD_SIZE-1:0] mem_wr_data,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int unsigned COL_W = $clog2(OUT_W + 1);
    localparam int unsigned ROW_W = $clog2(OUT_H + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [WORD_SIZE-1:0] data;
    } wr_entry_t;

    cfw_state_t        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic              vld, acc, last_pix, drop;
    logic              fifo_pop, fifo_full, fifo_empty;
    wr_entry_t         fifo_din, fifo_dout, wr_head;
    logic              unused_valid;

    assign unused_valid = valid_in[1];

    // Re-align valid with the pixel coming out of the product/sum/clamp pipeline.
    if (VALID_DELAY == 0) begin : g_no_delay
        assign vld = valid_in[0];
    end else begin : g_delay
        logic [VALID_DELAY-1:0] dly_q;
        always_ff @(posedge clk) begin
            if (rst) dly_q <= '0;
            else     dly_q <= (dly_q << 1) | VALID_DELAY'(valid_in[0]);
        end
        assign vld = dly_q[VALID_DELAY-1];
    end

    assign acc      = vld && (state_q == CAPTURE);
    assign last_pix = (row_q == ROW_W'(OUT_H - 1)) && (col_q == COL_W'(OUT_W - 1));
    assign fifo_pop = !fifo_empty && mem_ready;
    assign drop     = acc && fifo_full && !fifo_pop;
    assign fifo_din = '{addr: addr_q, data: pixel_in};

    sync_fifo #(
        .Width ($bits(wr_entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (acc),
        .pop_i   (fifo_pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CAPTURE;
            CAPTURE: if (acc && last_pix) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q == CAPTURE) || (state_q == DRAIN);
        frame_done = (state_q == DONE);
    end

    // Position counters advance on every accepted pixel, dropped or not, so later
    // addresses stay correct and the frame still terminates.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        ovf_d  = ovf_q;
        if (state_q == IDLE && start) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
            ovf_d  = 1'b0;
        end else if (acc) begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == COL_W'(OUT_W - 1)) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Mask the unreset FIFO storage so the write port reads zero while empty.
    assign wr_head     = fifo_empty ? '0 : fifo_dout;
    assign mem_wr_en   = !fifo_empty;
    assign mem_wr_addr = wr_head.addr;
    assign mem_wr_data = wr_head.data;
    assign overflow    = ovf_q;

endmodule

// File: doc/conv_frame_writer.md
Name: conv_frame_writer

Overview:
Receiving end of the convolution output stream. Consumes the (outputPixel, valid) pair produced by the 3x3 convolution stage and re-aligns the valid to the pixel pipeline. Tags each pixel with its linear output-frame address and writes it into frame memory through a small elastic FIFO with a ready-based write port. Reports frame completion and overflow when memory backpressure outlasts the FIFO.

Parameters:
WORD_SIZE, 8, pixel width in bits
ROW_SIZE, 540, input frame width; output width OUT_W = ROW_SIZE-2
COL_SIZE, 540, input frame height; output height OUT_H = COL_SIZE-2
VALID_DELAY, 3, cycles valid_in leads pixel_in (product, sum, clamp stages); 0 means already aligned
FIFO_DEPTH, 8, entries in elastic FIFO, power of two, >=2
ADDR_W, $clog2(OUT_W*OUT_H), memory address width (derived localparam)

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
start  in  1  arms capture of one frame (honoured only in IDLE)
pixel_in  in  WORD_SIZE  convolution output pixel
valid_in  in  2  convolution valid; only bit 0 is used
mem_wr_en  out  1  write request, FIFO head valid
mem_wr_addr  out  ADDR_W  linear address row*OUT_W+col
mem_wr_data  out  WORD_SIZE  pixel data
mem_ready  in  1  memory accepts the write this cycle
busy  out  1  high in CAPTURE or DRAIN
frame_done  out  1  one-cycle pulse at frame end
overflow  out  1  sticky; a pixel was dropped on FIFO full
Interface: one clock (clk). Reset rst is synchronous and active-high. All outputs are registered or driven from registered FIFO state.

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE. Counters, FIFO pointers and the valid delay line are cleared. Reset mid-frame abandons the frame without a frame_done.
- Valid alignment: shift register of VALID_DELAY stages on valid_in[0]. acc = delayed valid AND state==CAPTURE, sampled together with the current pixel_in.
- FSM states:
  - IDLE -> CAPTURE on start. On entry: clear overflow, col, row and accepted count.
  - CAPTURE -> DRAIN on the edge that accepts pixel number OUT_W*OUT_H.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE -> IDLE after one cycle, with frame_done=1 in DONE.
- start is ignored outside IDLE. Input valids are ignored outside CAPTURE.
- Address generation: {addr,data} is pushed on each acc, with addr = row*OUT_W+col.
  - col increments; at OUT_W-1 it wraps to 0 and row increments.
  - Use an incrementing address register; no multiplier.
- Dropped pixels: col, row and the accepted count advance even when the pixel is dropped. Addresses after a drop stay correct, and the frame still terminates.
- Write port:
  - mem_wr_en = FIFO not empty. mem_wr_addr and mem_wr_data show the FIFO head.
  - Pop occurs on mem_wr_en & mem_ready.
  - Head is held stable while mem_ready=0.
- Latency: a pixel accepted at edge k into an empty FIFO appears on mem_wr_en/addr/data in the cycle after edge k.
- Full rules:
  - Push while full with no pop: pixel dropped, overflow<=1.
  - Push and pop in the same cycle when full: push succeeds.
  - Push and pop when empty: the new entry appears next cycle; the FIFO is not bypassed.
- Overflow clears only on rst or on the next accepted start.
- busy is high in CAPTURE and DRAIN, and low in IDLE and DONE.

Decomposition:
- conv_pkg holds:
  - WORD_SIZE and KERNEL_DIM defaults
  - typedef enum {IDLE, CAPTURE, DRAIN, DONE} cfw_state_t
  - parameterised wr_entry_t struct {addr, data}
- One sub-module: sync_fifo (parameters: width and depth).
  - Ports: push, pop, din, dout, full, empty.
  - Registered pointers plus count.
  - Push-when-full-with-pop is permitted.

Test Plan:
(ROW_SIZE=5, COL_SIZE=5 -> 3x3 = 9 output pixels unless stated)
1. Assert rst for 2 cycles -> all outputs 0. One cycle after start: busy=1, overflow=0.
2. VALID_DELAY=0, mem_ready=1: start, then 9 consecutive valids with pixel_in=10..18 -> writes addr 0..8, data 10..18, in order, 1-cycle latency. frame_done pulses once, 2 cycles after the last write. busy then 0.
3. Valids before start and after frame_done -> no mem_wr_en. A second start captures a fresh frame starting at addr 0.
4. FIFO_DEPTH=4, mem_ready=0 during 9 back-to-back pixels, then 1 -> overflow=1 from the 5th pixel on. Only addr 0..3 are written, with data of pixels 1..4. frame_done still pulses. overflow stays 1 until the next start.
5. VALID_DELAY=3: valid_in=1 at cycle t, pixel_in=0xAA at t+3 and 0x55 elsewhere -> single write of 0xAA.
6. rst asserted after 4 of 9 pixels -> outputs 0 next cycle, no frame_done. start then writes a full frame from addr 0.
